// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
// Used by both the transmitter and the board's UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START_BIT = 2'd1,
        ST_DATA_BITS = 2'd2,
        ST_STOP_BIT  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last
// clock of every bit. Held at zero while i_Clear is high.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    output logic o_Bit_Tick,
    output logic o_Pre_Tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    // One clock before the tick; lets the caller register a last-clock flag.
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: wrap at the bit boundary, hold at zero when cleared.
    always_comb begin
        count_d = count_q + 1'b1;
        if (i_Clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Bit_Tick = (count_q == LAST);
    assign o_Pre_Tick = (count_q == PRE);

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter with a one-byte holding register so the next byte can
// be queued while the current frame shifts out; back-to-back frames have no gap.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        ready_q, active_q, serial_q, done_q;
    logic        serial_d, done_d;
    logic        load;
    logic        accept;
    logic        bit_tick, pre_tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Clear   (state_q == ST_IDLE),
        .o_Bit_Tick(bit_tick),
        .o_Pre_Tick(pre_tick)
    );

    assign accept = i_TX_DV && ready_q;

    // Next state, shifter load and holding-register bookkeeping.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        load      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load      = 1'b1;
                    shift_d   = hold_q;
                    bit_idx_d = '0;
                    state_d   = ST_START_BIT;
                end
            end
            ST_START_BIT: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = ST_DATA_BITS;
                end
            end
            ST_DATA_BITS: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_idx_d = '0;
                        state_d   = ST_STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_STOP_BIT: begin
                if (bit_tick) begin
                    if (hold_full_q) begin
                        load      = 1'b1;
                        shift_d   = hold_q;
                        bit_idx_d = '0;
                        state_d   = ST_START_BIT;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept and load never coincide: Ready is low whenever hold is full.
        hold_d      = accept ? i_TX_Byte : hold_q;
        hold_full_d = load ? 1'b0 : (accept ? 1'b1 : hold_full_q);
    end

    // Registered outputs are computed from the next state so they line up
    // with the state register rather than lagging it by a clock.
    always_comb begin
        serial_d = UART_IDLE_LEVEL;
        unique case (state_d)
            ST_IDLE:      serial_d = UART_IDLE_LEVEL;
            ST_START_BIT: serial_d = ~UART_IDLE_LEVEL;
            ST_DATA_BITS: serial_d = shift_d[bit_idx_d];
            ST_STOP_BIT:  serial_d = UART_IDLE_LEVEL;
            default:      serial_d = UART_IDLE_LEVEL;
        endcase
        done_d = (state_q == ST_STOP_BIT) && pre_tick;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            active_q    <= 1'b0;
            serial_q    <= UART_IDLE_LEVEL;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ~hold_full_d;
            active_q    <= (state_d != ST_IDLE);
            serial_q    <= serial_d;
            done_q      <= done_d;
        end
    end

    assign o_TX_Ready  = ready_q;
    assign o_TX_Active = active_q;
    assign o_TX_Serial = serial_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: CLKS_PER_BIT=4 instance for the
// protocol cases, a CLKS_PER_BIT=217 instance for the full-rate frame.
module tb_uart_tx_buffered;

    localparam int CPB  = 4;
    localparam int CPB2 = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] tx_byte = '0;
    logic       rdy, act, ser, done;

    logic       dv2 = 1'b0;
    logic [7:0] tx_byte2 = '0;
    logic       rdy2, act2, ser2, done2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_TX_DV    (dv),
        .i_TX_Byte  (tx_byte),
        .o_TX_Ready (rdy),
        .o_TX_Active(act),
        .o_TX_Serial(ser),
        .o_TX_Done  (done)
    );

    uart_tx_buffered #(.CLKS_PER_BIT(CPB2)) dut2 (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_TX_DV    (dv2),
        .i_TX_Byte  (tx_byte2),
        .o_TX_Ready (rdy2),
        .o_TX_Active(act2),
        .o_TX_Serial(ser2),
        .o_TX_Done  (done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for Ready at a falling edge, then strobe DV for one accept edge.
    task automatic start_send(input string tag, input logic [7:0] b);
        int n = 0;
        while (rdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(n < 100), 32'd1);
        dv      = 1'b1;
        tx_byte = b;
        @(posedge clk);
        #1 dv = 1'b0;
        check({tag, "_ready_after_accept"}, 32'(rdy), 32'd0);
    endtask

    // Called at the falling edge of the first start-bit clock; checks every
    // clock of the frame and returns at the falling edge after the stop bit.
    task automatic check_frame(input string tag, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            check({tag, "_serial"}, 32'(ser), 32'(frame[c / CPB]));
            check({tag, "_active"}, 32'(act), 32'd1);
            check({tag, "_done"},   32'(done), 32'(c == 10 * CPB - 1));
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            check({tag, "_serial"}, 32'(ser), 32'd1);
            check({tag, "_active"}, 32'(act), 32'd0);
            check({tag, "_done"},   32'(done), 32'd0);
            check({tag, "_ready"},  32'(rdy), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [9:0] frame2;
        logic [7:0] rx;
        int         ndone;

        // Reset and idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_serial", 32'(ser), 32'd1);
        check("rst_ready",  32'(rdy), 32'd1);
        check("rst_active", 32'(act), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        rst = 1'b0;
        check_idle("idle", 20);

        // Single frame 0xA5: one idle clock after accept, then 40-clock frame.
        start_send("a5", 8'hA5);
        @(negedge clk);
        check("a5_latency_serial", 32'(ser), 32'd1);
        check("a5_latency_active", 32'(act), 32'd0);
        @(negedge clk);
        check("a5_ready_after_load", 32'(rdy), 32'd1);
        check_frame("a5", 8'hA5);
        check_idle("a5_post", 4);

        // Back-to-back 0x3C / 0xC3 with a dropped 0xFF while Ready=0.
        start_send("3c", 8'h3C);
        @(negedge clk);
        @(negedge clk);
        fork
            begin
                check_frame("f3c", 8'h3C);
                check_frame("fc3", 8'hC3);
            end
            begin
                dv      = 1'b1;
                tx_byte = 8'hC3;
                @(posedge clk);
                #1 dv = 1'b0;
                check("c3_ready_after_accept", 32'(rdy), 32'd0);
                repeat (8) @(negedge clk);
                check("ff_ready_busy", 32'(rdy), 32'd0);
                dv      = 1'b1;
                tx_byte = 8'hFF;
                @(posedge clk);
                #1 dv = 1'b0;
            end
        join
        check_idle("b2b_post", 12);

        // Reset mid-data of 0x55 with 0x99 queued: both are lost.
        start_send("55", 8'h55);
        @(negedge clk);
        @(negedge clk);
        repeat (2) @(negedge clk);
        dv      = 1'b1;
        tx_byte = 8'h99;
        @(posedge clk);
        #1 dv = 1'b0;
        repeat (10) @(negedge clk);
        check("55_mid_active", 32'(act), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mrst_serial", 32'(ser), 32'd1);
        check("mrst_ready",  32'(rdy), 32'd1);
        check("mrst_active", 32'(act), 32'd0);
        check("mrst_done",   32'(done), 32'd0);
        @(negedge clk);
        check_idle("mrst_idle", 12);
        start_send("0f", 8'h0F);
        @(negedge clk);
        @(negedge clk);
        check_frame("f0f", 8'h0F);
        check_idle("0f_post", 4);

        // Full-rate instance: 0x81, each bit 217 clocks; decode at mid-bit.
        dv2      = 1'b1;
        tx_byte2 = 8'h81;
        @(posedge clk);
        #1 dv2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        frame2 = {1'b1, 8'h81, 1'b0};
        rx     = '0;
        ndone  = 0;
        for (int c = 0; c < 10 * CPB2; c++) begin
            check("w217_serial", 32'(ser2), 32'(frame2[c / CPB2]));
            check("w217_active", 32'(act2), 32'd1);
            if (done2 === 1'b1) ndone++;
            if ((c % CPB2) == CPB2 / 2 && c / CPB2 >= 1 && c / CPB2 <= 8) begin
                rx = {ser2, rx[7:1]};
            end
            @(negedge clk);
        end
        check("w217_rx_byte", 32'(rx), 32'h81);
        check("w217_done_count", 32'(ndone), 32'd1);
        check("w217_post_serial", 32'(ser2), 32'd1);
        check("w217_post_active", 32'(act2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
